// File: rtl/bus_cycle_ctl_pkg.sv
// Shared types and widths for the CFT bus cycle controller and its counter block.
package bus_cycle_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Kind of the transaction latched at accept time.
  typedef struct packed {
    logic io;  // 0 = memory space (nmem), 1 = I/O space (nio)
    logic wr;  // 0 = read (nr), 1 = write (nw)
  } kind_t;

  localparam int WS_W  = 8;
  localparam int MIN_W = 4;

endpackage

// File: rtl/bus_cycle_ctl_ws_ctr.sv
// Strobe timing counters: MIN_WAIT down-counter, then a wait-state up-counter
// that saturates at WS_TIMEOUT and flags the timeout.
module bus_cycle_ctl_ws_ctr
  import bus_cycle_ctl_pkg::*;
#(
  parameter int MIN_WAIT   = 1,
  parameter int WS_TIMEOUT = 255
) (
  input  logic clk4,
  input  logic nreset,
  input  logic load,
  input  logic in_strobe,
  input  logic wait_req,
  output logic min_expired,
  output logic timeout
);

  localparam logic [MIN_W-1:0] MIN_LOAD = MIN_W'(MIN_WAIT - 1);
  localparam logic [WS_W-1:0]  WS_LIMIT = WS_W'(WS_TIMEOUT);

  logic [MIN_W-1:0] min_cnt;
  logic [WS_W-1:0]  ws_cnt;

  assign min_expired = (min_cnt == '0);
  // Timeout means WS_TIMEOUT wait cycles have already been granted.
  assign timeout     = (ws_cnt == WS_LIMIT);

  always_ff @(posedge clk4 or negedge nreset) begin
    if (!nreset) begin
      min_cnt <= '0;
      ws_cnt  <= '0;
    end else if (load) begin
      min_cnt <= MIN_LOAD;
      ws_cnt  <= '0;
    end else if (in_strobe) begin
      if (!min_expired) begin
        min_cnt <= min_cnt - 1'b1;
      end else if (wait_req && !timeout) begin
        ws_cnt <= ws_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_cycle_ctl.sv
// CFT system bus cycle controller: one request at a time, sequenced as
// SETUP / STROBE (stretched by nws) / HOLD with every output registered.
module bus_cycle_ctl
  import bus_cycle_ctl_pkg::*;
#(
  parameter int MIN_WAIT   = 1,
  parameter int WS_TIMEOUT = 255
) (
  input  logic        clk4,
  input  logic        nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_io,
  input  logic        req_wr,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        nhalt,
  input  logic        nws,
  output logic [23:0] ab,
  input  logic [15:0] db_in,
  output logic [15:0] db_out,
  output logic        db_oe,
  output logic        nmem,
  output logic        nio,
  output logic        nr,
  output logic        nw,
  output logic [15:0] rdata,
  output logic        done,
  output logic        buserr,
  output state_t      dbg_state
);

  // Handshake: a request is taken on a rising clk4 edge where req_valid and
  // req_ready are both high; req_ready is only high in IDLE with nhalt high,
  // and a request presented while req_ready is low is dropped, not queued.

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        nws_q;
  logic        min_expired, timeout;
  logic        ready_d, db_oe_d, nmem_d, nio_d, nr_d, nw_d, done_d, buserr_d;
  logic [23:0] ab_d;
  logic [15:0] db_out_d, rdata_d;

  bus_cycle_ctl_ws_ctr #(
    .MIN_WAIT  (MIN_WAIT),
    .WS_TIMEOUT(WS_TIMEOUT)
  ) u_ws_ctr (
    .clk4       (clk4),
    .nreset     (nreset),
    .load       (state_q == ST_SETUP),
    .in_strobe  (state_q == ST_STROBE),
    .wait_req   (!nws_q),
    .min_expired(min_expired),
    .timeout    (timeout)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    ab_d     = ab;
    db_out_d = db_out;
    db_oe_d  = db_oe;
    nmem_d   = nmem;
    nio_d    = nio;
    nr_d     = 1'b1;
    nw_d     = 1'b1;
    done_d   = 1'b0;
    buserr_d = 1'b0;
    rdata_d  = rdata;
    case (state_q)
      ST_IDLE: begin
        nmem_d  = 1'b1;
        nio_d   = 1'b1;
        db_oe_d = 1'b0;
        if (req_valid && req_ready) begin
          state_d  = ST_SETUP;
          kind_d   = '{io: req_io, wr: req_wr};
          ab_d     = req_addr;
          db_out_d = req_wdata;
          nmem_d   = req_io;
          nio_d    = !req_io;
          db_oe_d  = req_wr;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        nr_d    = kind_q.wr;
        nw_d    = !kind_q.wr;
      end
      ST_STROBE: begin
        nr_d = kind_q.wr;
        nw_d = !kind_q.wr;
        // Registered nws is only honoured once the minimum strobe has elapsed.
        if (min_expired && (nws_q || timeout)) begin
          state_d  = ST_HOLD;
          nr_d     = 1'b1;
          nw_d     = 1'b1;
          done_d   = 1'b1;
          buserr_d = !nws_q;
          if (!kind_q.wr) rdata_d = nws_q ? db_in : 16'hFFFF;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        nmem_d  = 1'b1;
        nio_d   = 1'b1;
        db_oe_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE) && nhalt;
  end

  always_ff @(posedge clk4 or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      kind_q    <= '0;
      nws_q     <= 1'b1;
      req_ready <= 1'b1;
      ab        <= '0;
      db_out    <= '0;
      db_oe     <= 1'b0;
      nmem      <= 1'b1;
      nio       <= 1'b1;
      nr        <= 1'b1;
      nw        <= 1'b1;
      rdata     <= '0;
      done      <= 1'b0;
      buserr    <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      nws_q     <= nws;
      req_ready <= ready_d;
      ab        <= ab_d;
      db_out    <= db_out_d;
      db_oe     <= db_oe_d;
      nmem      <= nmem_d;
      nio       <= nio_d;
      nr        <= nr_d;
      nw        <= nw_d;
      rdata     <= rdata_d;
      done      <= done_d;
      buserr    <= buserr_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// Self-checking bench for bus_cycle_ctl: directed scenarios plus randomized
// transactions compared against a cycle-count reference model.
module tb_bus_cycle_ctl;
  import bus_cycle_ctl_pkg::*;

  localparam int MIN_WAIT   = 1;
  localparam int WS_TIMEOUT = 8;

  logic        clk4 = 1'b0;
  logic        nreset = 1'b1;
  logic        req_valid = 1'b0, req_io = 1'b0, req_wr = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0, db_in = '0;
  logic        nhalt = 1'b1, nws = 1'b1;
  logic        req_ready, db_oe, nmem, nio, nr, nw, done, buserr;
  logic [23:0] ab;
  logic [15:0] db_out, rdata;
  state_t      dbg_state;

  int          total = 0;
  int          passed = 0;
  int          inv_viol = 0;
  logic [15:0] rdata_model = '0;

  always #5 clk4 = ~clk4;

  bus_cycle_ctl #(.MIN_WAIT(MIN_WAIT), .WS_TIMEOUT(WS_TIMEOUT)) dut (
    .clk4(clk4), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_io(req_io), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .nhalt(nhalt), .nws(nws), .ab(ab), .db_in(db_in), .db_out(db_out),
    .db_oe(db_oe), .nmem(nmem), .nio(nio), .nr(nr), .nw(nw), .rdata(rdata),
    .done(done), .buserr(buserr), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bus invariants, sampled on the falling edge.
  always @(negedge clk4) begin
    if (nreset) begin
      if (!nr && !nw) inv_viol++;
      if (!nmem && !nio) inv_viol++;
      if (db_oe && !nr) inv_viol++;
    end
  end

  // One transaction: w is how many wait samples the peripheral requests,
  // halt_at (>=0) drops nhalt at that sample index.
  task automatic run_txn(input logic io, input logic wr, input logic [23:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rd_val,
                         input int w, input int halt_at, input string tag);
    int   wcap, exp_done, k_done, n_sp, n_rw, n_other, n_oe, n_err, guard;
    logic exp_err, ab_ok, dout_ok;
    wcap     = (w < WS_TIMEOUT) ? w : WS_TIMEOUT;
    exp_err  = (w > WS_TIMEOUT);
    exp_done = 1 + MIN_WAIT + wcap;
    guard = 0;
    @(negedge clk4);
    while (!req_ready && guard < 50) begin
      @(negedge clk4);
      guard++;
    end
    check({tag, "_ready_in"}, req_ready, 1);
    req_valid = 1'b1; req_io = io; req_wr = wr; req_addr = addr;
    req_wdata = wdata; db_in = rd_val; nws = (w == 0);
    @(posedge clk4); #1;
    req_valid = 1'b0;
    k_done = -1; n_sp = 0; n_rw = 0; n_other = 0; n_oe = 0; n_err = 0;
    ab_ok = 1'b1; dout_ok = 1'b1;
    for (int k = 0; k < 40 && k_done < 0; k++) begin
      if (k > 0) begin
        @(posedge clk4); #1;
      end
      if (!(io ? nio : nmem)) n_sp++;
      if (!(io ? nmem : nio)) n_other++;
      if (!(wr ? nw : nr)) n_rw++;
      if (!(wr ? nr : nw)) n_other++;
      if (db_oe) n_oe++;
      if (ab !== addr) ab_ok = 1'b0;
      if (wr && db_out !== wdata) dout_ok = 1'b0;
      if (buserr) n_err++;
      if (done) k_done = k;
      if (k >= w) nws = 1'b1;
      if (k == halt_at) nhalt = 1'b0;
    end
    nws = 1'b1;
    if (!wr) rdata_model = exp_err ? 16'hFFFF : rd_val;
    check({tag, "_done_cycle"}, k_done, exp_done);
    check({tag, "_buserr"}, n_err, exp_err);
    check({tag, "_space_low"}, n_sp, exp_done + 1);
    check({tag, "_rw_low"}, n_rw, MIN_WAIT + wcap);
    check({tag, "_other_low"}, n_other, 0);
    check({tag, "_db_oe"}, n_oe, wr ? exp_done + 1 : 0);
    check({tag, "_ab"}, ab_ok, 1);
    check({tag, "_db_out"}, dout_ok, 1);
    check({tag, "_rdata"}, rdata, rdata_model);
    @(posedge clk4); #1;
    check({tag, "_ready_out"}, req_ready, (halt_at < 0) ? 1 : 0);
    check({tag, "_released"}, {nmem, nio, nr, nw, done}, 5'b11110);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts, n_done, last_done, n_fall, n_idle, stall_bad;
    logic sp_prev;

    // Reset state
    #1 nreset = 1'b0;
    #3;
    check("rst_strobes", {nmem, nio, nr, nw}, 4'hF);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_flags", {db_oe, done, buserr}, 3'b000);
    check("rst_ab_db", {ab, db_out}, 40'h0);
    check("rst_rdata", rdata, 16'h0);
    repeat (2) @(negedge clk4);
    nreset = 1'b1;
    @(negedge clk4);
    check("rst_ready", req_ready, 1);

    // Directed: memory read, I/O write with waits, wait-state timeout
    run_txn(1'b0, 1'b0, 24'h001234, 16'h0000, 16'hBEEF, 0, -1, "t1_rd");
    run_txn(1'b1, 1'b1, 24'h000301, 16'h5A5A, 16'h1111, 4, -1, "t2_wr");
    run_txn(1'b0, 1'b0, 24'h00ABCD, 16'h0000, 16'h1234, 30, -1, "t3_to");
    run_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 16'h7777, WS_TIMEOUT, -1, "t3_edge");

    // Back-to-back writes with req_valid held high
    @(negedge clk4);
    req_valid = 1'b1; req_io = 1'b0; req_wr = 1'b1;
    req_addr = 24'h00_4000; req_wdata = 16'hC0DE; nws = 1'b1;
    accepts = 0; n_done = 0; last_done = -1; n_fall = 0; n_idle = 0; sp_prev = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk4);
      if (done) begin
        n_done++;
        last_done = c;
      end
      if (sp_prev && !nmem) n_fall++;
      sp_prev = nmem;
      if (c > 0 && c < 11 && {nmem, nio, nr, nw} == 4'hF) n_idle++;
      if (req_valid && req_ready) begin
        accepts++;
        if (accepts == 3) begin
          @(posedge clk4); #1;
          req_valid = 1'b0;
        end
      end
    end
    check("b2b_accepts", accepts, 3);
    check("b2b_done", n_done, 3);
    check("b2b_last_done", last_done, 11);
    check("b2b_setups", n_fall, 3);
    check("b2b_idle_gaps", n_idle, 2);

    // nhalt low in IDLE blocks accepts
    @(negedge clk4);
    nhalt = 1'b0;
    @(negedge clk4);
    req_valid = 1'b1;
    stall_bad = 0;
    repeat (5) begin
      @(negedge clk4);
      if (req_ready || !nmem || !nio || done) stall_bad++;
    end
    check("halt_idle", stall_bad, 0);
    req_valid = 1'b0;
    nhalt = 1'b1;
    @(negedge clk4);
    check("halt_release", req_ready, 1);

    // nhalt low during STROBE: cycle completes, then stall
    run_txn(1'b0, 1'b1, 24'h00_0777, 16'h3C3C, 16'h0, 2, 1, "t5_halt");
    @(negedge clk4);
    req_valid = 1'b1;
    stall_bad = 0;
    repeat (4) begin
      @(negedge clk4);
      if (req_ready || !nmem || !nio) stall_bad++;
    end
    check("halt_stall", stall_bad, 0);
    req_valid = 1'b0;
    nhalt = 1'b1;

    // Randomized transactions
    for (int i = 0; i < 12; i++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              24'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 11), -1, $sformatf("rnd%0d", i));
    end

    // Reset asserted mid-STROBE
    @(negedge clk4);
    req_valid = 1'b1; req_io = 1'b0; req_wr = 1'b0; req_addr = 24'h00_5555;
    nws = 1'b0;
    @(posedge clk4); #1;
    req_valid = 1'b0;
    @(posedge clk4); #1;
    check("t6_in_strobe", nr, 0);
    #2 nreset = 1'b0;
    #1;
    check("t6_strobes", {nmem, nio, nr, nw, db_oe}, 5'b11110);
    check("t6_state", dbg_state, ST_IDLE);
    @(negedge clk4);
    nreset = 1'b1; nws = 1'b1;
    rdata_model = '0;
    n_done = 0;
    repeat (6) begin
      @(negedge clk4);
      if (done || buserr) n_done++;
    end
    check("t6_no_done", n_done, 0);
    check("t6_ready", req_ready, 1);
    check("t6_rdata", rdata, rdata_model);

    check("invariants", inv_viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
